dm_sync_be: RTL and testbench
=============================

Name: dm_sync_be

Overview:
- Second-generation data memory for the pipelined MIPS core's MEM stage.
- Word array with byte-enable stores and synchronous (1-cycle) reads, so it maps onto block RAM.
- Adds unsigned loads, alignment and range exceptions, and a synthesisable zero-fill FSM that runs after reset.
- Store trace is exported on registered ports for the testbench logger; there are no in-RTL prints.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words.
- IDX_W, $clog2(DEPTH_WORDS), word-index width; addr[IDX_W+1:2] is the index.
- BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be 4-aligned.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  high when a request is accepted this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_op  input  3  access type, DM_* encoding (see Decomposition).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_pc  input  32  PC of the requesting instruction, used for the trace only.
- rdata_valid  output  1  one-cycle pulse carrying load data.
- rdata  output  32  extended load data.
- exc_adel  output  1  one-cycle pulse: load address error.
- exc_ades  output  1  one-cycle pulse: store address error.
- wlog_valid  output  1  one-cycle pulse: a store committed.
- wlog_pc, wlog_addr, wlog_data  output  32 each  PC, byte address, and lane-positioned store data.
- wlog_be  output  4  byte lanes written.
- init_done  output  1  high once the zero-fill has completed.

Behaviour:
- Reset (async assert): FSM goes to INIT and the sweep counter is 0.
  - All outputs are 0: req_ready, rdata_valid, rdata, exc_*, wlog_*, init_done.
  - Memory contents are not touched by reset itself.
- FSM state INIT:
  - Each cycle writes word[counter] <= 0, then counter++.
  - After the cycle that writes word DEPTH_WORDS-1, the FSM goes to RUN.
  - Init therefore takes exactly DEPTH_WORDS cycles after reset deassertion.
  - req_ready = 0 during INIT.
  - A reset asserted during INIT restarts the sweep at 0.
- FSM state RUN:
  - req_ready = 1 and init_done = 1.
  - A request is accepted in any cycle where req_valid is high. There is no back-pressure and one request is accepted per cycle.
- Address check on an accepted request at edge N. Define off = req_addr - BASE_ADDR.
  - Range error: off >= 4*DEPTH_WORDS, including wrap when req_addr < BASE_ADDR.
  - Alignment error:
    - WORD requires off[1:0] == 0.
    - HALF/HALFU require off[0] == 0.
    - BYTE/BYTEU are always aligned.
  - On error: no array write and no rdata_valid. The cycle after N pulses exc_adel (load) or exc_ades (store); the pulse lasts exactly one cycle.
- Load, no error:
  - The array is read at edge N.
  - At cycle N+1: rdata_valid = 1 and rdata is selected by off[1:0].
    - WORD: whole word.
    - HALF: sign-extended half. Lane [15:0] when off[1]=0, lane [31:16] when off[1]=1.
    - HALFU: same lane selection as HALF, zero-extended.
    - BYTE: sign-extended lane off[1:0].
    - BYTEU: same lane as BYTE, zero-extended.
  - rdata holds its value when rdata_valid = 0.
- Store, no error:
  - Lanes written at edge N:
    - WORD: be = 4'b1111.
    - HALF: be = 4'b0011 << off[1:0].
    - BYTE: be = 4'b0001 << off[1:0].
  - Data is replicated into the lanes: byte into all 4, half into both halves.
  - Unselected lanes are preserved; no read-modify-write is performed.
  - At cycle N+1: wlog_valid = 1, wlog_pc = req_pc, wlog_addr = req_addr, wlog_be = be, and wlog_data = replicated data with non-enabled lanes forced to 0.
- Unsigned ops (HALFU/BYTEU) with req_we = 1 are stored exactly like HALF/BYTE.
- Illegal op codes (5-7): the request is accepted with no write and no pulse on any output.
- Store at N followed by a load of the same word at N+1 returns the new data at N+2. Array write-then-read ordering covers this, so no bypass path is needed.
- Reset asserted while a response is pending cancels the pending pulse.

Decomposition:
- Shared package (dm_pkg) holds:
  - DM_WORD=3'd0, DM_HALF=3'd1, DM_BYTE=3'd2, DM_HALFU=3'd3, DM_BYTEU=3'd4. The first three keep their existing values.
  - FSM state constants ST_INIT and ST_RUN.
- One sub-module, dm_be_ram: DEPTH×32 single-port RAM with 4-bit byte-enable write and registered read. The INIT sweep and RUN requests share its port through a mux in dm_sync_be.

Test Plan:
- Release reset and count cycles: init_done and req_ready rise exactly DEPTH_WORDS cycles later. Assert reset mid-sweep at cycle 100: the sweep restarts and takes another full DEPTH_WORDS cycles.
- SW 0x8899AABB @0x10, then LW @0x10: wlog_be=1111; the load returns rdata=0x8899AABB one cycle after acceptance.
- SB 0x7F @0x13, then LB/LBU @0x13: wlog_be=1000 and wlog_data=0x7F000000. Then SB 0x80 @0x12: LB @0x12 returns 0xFFFFFF80 and LBU @0x12 returns 0x00000080.
- SH 0xBEEF @0x22 over an existing word 0x11223344 at 0x20: LW @0x20 returns 0xBEEF3344, LH @0x22 returns 0xFFFFBEEF, LHU @0x22 returns 0x0000BEEF.
- LW @0x02, SH @0x05, and LW @0x3000 (DEPTH 3072): each produces a single exc_adel/exc_ades pulse and no rdata_valid. LW @0x00 afterwards is unchanged.
- Back-to-back: SW 0xCAFE0001 @0x40 at cycle N, then LW @0x40 at N+1 → rdata=0xCAFE0001 at N+2. Op=3'd6 with req_we=1 → no wlog pulse and memory unchanged.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the byte-enable data memory: access op codes, FSM
// states and the load-extension helper used on the read return path.
package dm_pkg;

    localparam logic [2:0] DM_WORD  = 3'd0;
    localparam logic [2:0] DM_HALF  = 3'd1;
    localparam logic [2:0] DM_BYTE  = 3'd2;
    localparam logic [2:0] DM_HALFU = 3'd3;
    localparam logic [2:0] DM_BYTEU = 3'd4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dm_state_t;

    // Picks the addressed lane out of a raw array word and sign/zero extends it.
    function automatic logic [31:0] dm_load_ext(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  op);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = lane[1] ? word[31:16] : word[15:0];
        b = word[{lane, 3'b000} +: 8];
        case (op)
            DM_HALF:  r = {{16{h[15]}}, h};
            DM_HALFU: r = {16'h0000, h};
            DM_BYTE:  r = {{24{b[7]}}, b};
            DM_BYTEU: r = {24'h000000, b};
            default:  r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_be_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port;
// no reset on the array or the read register so it maps onto block RAM.
module dm_be_ram #(
    parameter int DEPTH_WORDS = 3072,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    input  logic             re,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        // Read-before-write on a shared address; a load the cycle after a
        // store to the same word still sees the new data.
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dm_sync_be.sv
// MEM-stage data memory: zero-fill sweep after reset, then byte-enable stores,
// synchronous extended loads, address exceptions and a registered store trace.
module dm_sync_be
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 3072,
    parameter int          IDX_W       = $clog2(DEPTH_WORDS),
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        wlog_valid,
    output logic [31:0] wlog_pc,
    output logic [31:0] wlog_addr,
    output logic [31:0] wlog_data,
    output logic [3:0]  wlog_be,
    output logic        init_done
);

    localparam logic [31:0]      SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH_WORDS - 1);

    dm_state_t        state_q, state_d;
    logic [IDX_W-1:0] cnt_q;

    logic        accept, op_legal, is_word, is_half, is_byte;
    logic        addr_err, do_load, do_store;
    logic [31:0] off, rep, lane_mask;
    logic [3:0]  be;

    logic             ram_we, ram_re;
    logic [3:0]       ram_be;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]      ram_wdata, ram_rdata;

    logic [1:0]  ld_lane_q;
    logic [2:0]  ld_op_q;
    logic [31:0] rdata_hold_q, ld_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) cnt_q <= cnt_q + IDX_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        init_done = 1'b0;
        case (state_q)
            ST_INIT: if (cnt_q == CNT_LAST) state_d = ST_RUN;
            ST_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Handshake: a request transfers on every rising edge where req_valid and
    // req_ready are both high; req_ready never depends on req_valid.
    always_comb begin
        accept   = req_valid & req_ready;
        off      = req_addr - BASE_ADDR;
        is_word  = (req_op == DM_WORD);
        is_half  = (req_op == DM_HALF) | (req_op == DM_HALFU);
        is_byte  = (req_op == DM_BYTE) | (req_op == DM_BYTEU);
        op_legal = is_word | is_half | is_byte;
        addr_err = op_legal & ((off >= SPAN) | (is_word & (|off[1:0])) | (is_half & off[0]));
        do_load  = accept & ~req_we & op_legal & ~addr_err;
        do_store = accept &  req_we & op_legal & ~addr_err;

        be  = 4'b0000;
        rep = req_wdata;
        if (is_word) begin
            be = 4'b1111;
        end else if (is_half) begin
            be  = 4'b0011 << off[1:0];
            rep = {2{req_wdata[15:0]}};
        end else if (is_byte) begin
            be  = 4'b0001 << off[1:0];
            rep = {4{req_wdata[7:0]}};
        end
        lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    end

    // The sweep owns the RAM port until RUN; requests are not accepted before then.
    always_comb begin
        if (state_q == ST_INIT) begin
            ram_we    = 1'b1;
            ram_be    = 4'b1111;
            ram_addr  = cnt_q;
            ram_wdata = '0;
        end else begin
            ram_we    = do_store;
            ram_be    = be;
            ram_addr  = off[IDX_W+1:2];
            ram_wdata = rep;
        end
        ram_re = do_load;
    end

    dm_be_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_valid  <= 1'b0;
            ld_lane_q    <= '0;
            ld_op_q      <= DM_WORD;
            rdata_hold_q <= '0;
            exc_adel     <= 1'b0;
            exc_ades     <= 1'b0;
            wlog_valid   <= 1'b0;
            wlog_pc      <= '0;
            wlog_addr    <= '0;
            wlog_data    <= '0;
            wlog_be      <= '0;
        end else begin
            rdata_valid <= do_load;
            exc_adel    <= accept & addr_err & ~req_we;
            exc_ades    <= accept & addr_err &  req_we;
            wlog_valid  <= do_store;
            if (do_load) begin
                ld_lane_q <= off[1:0];
                ld_op_q   <= req_op;
            end
            if (rdata_valid) rdata_hold_q <= ld_ext;
            if (do_store) begin
                wlog_pc   <= req_pc;
                wlog_addr <= req_addr;
                wlog_data <= rep & lane_mask;
                wlog_be   <= be;
            end
        end
    end

    // The extension runs straight off the RAM output register so load data
    // lands one cycle after acceptance; the hold register keeps rdata stable.
    assign ld_ext = dm_load_ext(ram_rdata, ld_lane_q, ld_op_q);
    assign rdata  = rdata_valid ? ld_ext : rdata_hold_q;

endmodule

// File: tb/tb_dm_sync_be.sv
// Bench for dm_sync_be: init sweep timing, directed load/store cases and
// randomized traffic checked against a byte-array reference model.
module tb_dm_sync_be;

    localparam int unsigned DEPTH = 3072;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
    logic        req_ready, rdata_valid, exc_adel, exc_ades, wlog_valid, init_done;
    logic [31:0] rdata, wlog_pc, wlog_addr, wlog_data;
    logic [3:0]  wlog_be;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem_m [4*DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] rdata_hold_m = '0;

    dm_sync_be #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .rdata_valid(rdata_valid), .rdata(rdata),
        .exc_adel(exc_adel), .exc_ades(exc_ades),
        .wlog_valid(wlog_valid), .wlog_pc(wlog_pc), .wlog_addr(wlog_addr),
        .wlog_data(wlog_data), .wlog_be(wlog_be), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle of traffic: compute the expected response from the byte model,
    // clock the request in, then compare everything visible one cycle later.
    task automatic drive(input logic v, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc);
        int unsigned off, size;
        logic        legal, err, exp_rv, exp_adel, exp_ades, exp_wv;
        logic [31:0] val, exp_data, exp_rd;
        logic [3:0]  exp_be;
        off   = addr - BASE;
        legal = (op <= 3'd4);
        size  = (op == 3'd0) ? 4 : ((op == 3'd1 || op == 3'd3) ? 2 : 1);
        err   = legal && (off >= 4*DEPTH || (off % size) != 0);
        exp_rv   = v && legal && !err && !we;
        exp_wv   = v && legal && !err && we;
        exp_adel = v && legal && err && !we;
        exp_ades = v && legal && err && we;
        exp_be   = '0;
        exp_data = '0;
        if (exp_rv) begin
            val = '0;
            for (int k = 0; k < int'(size); k++) val = val | (32'(mem_m[off+k]) << (8*k));
            if ((op == 3'd1 && val[15]) || (op == 3'd2 && val[7]))
                val = val | ~((32'd1 << (8*size)) - 32'd1);
            exp_q.push_back(val);
        end
        if (exp_wv) begin
            for (int k = 0; k < int'(size); k++) begin
                mem_m[off+k] = wdata[8*k +: 8];
                exp_be[(off % 4) + k] = 1'b1;
                exp_data[8*((off % 4) + k) +: 8] = wdata[8*k +: 8];
            end
        end
        req_valid = v; req_we = we; req_op = op;
        req_addr = addr; req_wdata = wdata; req_pc = pc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
        if (exp_rv) begin
            exp_rd = exp_q.pop_front();
            check("rdata", rdata, exp_rd);
            rdata_hold_m = exp_rd;
        end else begin
            check("rdata_hold", rdata, rdata_hold_m);
        end
        check("exc_adel", 32'(exc_adel), 32'(exp_adel));
        check("exc_ades", 32'(exc_ades), 32'(exp_ades));
        check("wlog_valid", 32'(wlog_valid), 32'(exp_wv));
        if (exp_wv) begin
            check("wlog_pc", wlog_pc, pc);
            check("wlog_addr", wlog_addr, addr);
            check("wlog_be", 32'(wlog_be), 32'(exp_be));
            check("wlog_data", wlog_data, exp_data);
        end
    endtask

    initial begin
        int cycles;
        logic [31:0] a;
        for (int i = 0; i < int'(4*DEPTH); i++) mem_m[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_exc", 32'({exc_adel, exc_ades}), 32'd0);
        check("rst_wlog", 32'({wlog_valid, wlog_be}), 32'd0);
        check("rst_wlog_data", wlog_data, 32'd0);

        // Abort a sweep at cycle 100, then time a full one
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("mid_sweep_done", 32'(init_done), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_sweep_rst_ready", 32'(req_ready), 32'd0);
        #2;
        reset = 1'b1;
        cycles = 0;
        while (!init_done && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("init_cycles", 32'(cycles), 32'(DEPTH));
        check("init_ready", 32'(req_ready), 32'd1);

        // Word store / load
        drive(1, 1, 3'd0, 32'h10, 32'h8899AABB, 32'h400);
        check("sw10_be", 32'(wlog_be), 32'hF);
        drive(1, 0, 3'd0, 32'h10, 32'h0, 32'h404);
        check("lw10", rdata, 32'h8899AABB);

        // Byte store / signed and unsigned byte loads
        drive(1, 1, 3'd2, 32'h13, 32'h0000007F, 32'h408);
        check("sb13_be", 32'(wlog_be), 32'h8);
        check("sb13_data", wlog_data, 32'h7F000000);
        drive(1, 0, 3'd2, 32'h13, 32'h0, 32'h40C);
        check("lb13", rdata, 32'h0000007F);
        drive(1, 0, 3'd4, 32'h13, 32'h0, 32'h410);
        check("lbu13", rdata, 32'h0000007F);
        drive(1, 1, 3'd2, 32'h12, 32'hFFFFFF80, 32'h414);
        drive(1, 0, 3'd2, 32'h12, 32'h0, 32'h418);
        check("lb12", rdata, 32'hFFFFFF80);
        drive(1, 0, 3'd4, 32'h12, 32'h0, 32'h41C);
        check("lbu12", rdata, 32'h00000080);

        // Half store over an existing word
        drive(1, 1, 3'd0, 32'h20, 32'h11223344, 32'h420);
        drive(1, 1, 3'd1, 32'h22, 32'h0000BEEF, 32'h424);
        check("sh22_be", 32'(wlog_be), 32'hC);
        drive(1, 0, 3'd0, 32'h20, 32'h0, 32'h428);
        check("lw20", rdata, 32'hBEEF3344);
        drive(1, 0, 3'd1, 32'h22, 32'h0, 32'h42C);
        check("lh22", rdata, 32'hFFFFBEEF);
        drive(1, 0, 3'd3, 32'h22, 32'h0, 32'h430);
        check("lhu22", rdata, 32'h0000BEEF);

        // Alignment and range exceptions
        drive(1, 0, 3'd0, 32'h02, 32'h0, 32'h434);
        check("lw02_adel", 32'(exc_adel), 32'd1);
        drive(0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
        check("adel_one_cycle", 32'(exc_adel), 32'd0);
        drive(1, 1, 3'd1, 32'h05, 32'h1234, 32'h438);
        check("sh05_ades", 32'(exc_ades), 32'd1);
        drive(1, 0, 3'd0, 32'h3000, 32'h0, 32'h43C);
        check("lw3000_adel", 32'(exc_adel), 32'd1);
        drive(1, 0, 3'd0, 32'h00, 32'h0, 32'h440);
        check("lw00", rdata, 32'h0);

        // Back-to-back store then load, and an illegal op
        drive(1, 1, 3'd0, 32'h40, 32'hCAFE0001, 32'h444);
        drive(1, 0, 3'd0, 32'h40, 32'h0, 32'h448);
        check("b2b_lw40", rdata, 32'hCAFE0001);
        drive(1, 1, 3'd6, 32'h40, 32'h0, 32'h44C);
        check("op6_no_wlog", 32'(wlog_valid), 32'd0);
        drive(1, 0, 3'd0, 32'h40, 32'h0, 32'h450);
        check("op6_mem_kept", rdata, 32'hCAFE0001);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = BASE + 32'(4*DEPTH - 8) + 32'($urandom_range(0, 15));
                default: a = BASE + 32'($urandom_range(0, 255));
            endcase
            drive(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), a, $urandom, $urandom);
        end

        // Reset while a load response is pending
        drive(1, 0, 3'd0, 32'h40, 32'h0, 32'h454);
        reset = 1'b0;
        #1;
        check("rst_cancel_rvalid", 32'(rdata_valid), 32'd0);
        check("rst_cancel_rdata", rdata, 32'd0);
        check("rst_cancel_ready", 32'(req_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
